// File: rtl/ula_pkg.sv
// Shared constants for the ula arithmetic/logic unit: data width, opcodes and compare codes.
package ula_pkg;
    localparam int DATA_W = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;
endpackage

// File: rtl/ula_comb.sv
// Combinational operation decode and datapath; produces the next result, overflow and compare code.
module ula_comb
    import ula_pkg::*;
(
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result_next,
    output logic              overflow_next,
    output logic [1:0]        compare_next
);
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] product;
    logic                shift_in_range;

    assign sum            = operand_a + operand_b;
    assign diff           = operand_a - operand_b;
    assign product        = {{DATA_W{1'b0}}, operand_a} * {{DATA_W{1'b0}}, operand_b};
    // Any bit set above bit 4 means the shift amount is at least 32.
    assign shift_in_range = (operand_b[DATA_W-1:5] == '0);

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        compare_next  = CMP_EQ;
        case (opcode)
            OP_ADD: begin
                result_next   = sum;
                overflow_next = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                                (sum[DATA_W-1] != operand_a[DATA_W-1]);
            end
            OP_SUB: begin
                result_next   = diff;
                overflow_next = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                                (diff[DATA_W-1] != operand_a[DATA_W-1]);
            end
            OP_MUL: begin
                result_next   = product[DATA_W-1:0];
                overflow_next = (product[2*DATA_W-1:DATA_W] != '0);
            end
            OP_DIV: begin
                if (operand_b == '0) begin
                    result_next   = '1;
                    overflow_next = 1'b1;
                end else begin
                    result_next = operand_a / operand_b;
                end
            end
            OP_AND: result_next = operand_a & operand_b;
            OP_OR:  result_next = operand_a | operand_b;
            OP_NOT: result_next = ~operand_a;
            OP_SHL: result_next = shift_in_range ? (operand_a << operand_b[4:0]) : '0;
            OP_SHR: result_next = shift_in_range ? (operand_a >> operand_b[4:0]) : '0;
            OP_CMP: begin
                if (operand_a < operand_b)      compare_next = CMP_LT;
                else if (operand_a > operand_b) compare_next = CMP_GT;
                else                            compare_next = CMP_EQ;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ula.sv
// Registered 32-bit ALU: one-cycle latency from operands/opcode to result, overflow and compare code.
module ula
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic [1:0]        compareResult
);
    logic [DATA_W-1:0] result_next;
    logic              overflow_next;
    logic [1:0]        compare_next;

    ula_comb u_comb (
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .opcode        (opcode),
        .result_next   (result_next),
        .overflow_next (overflow_next),
        .compare_next  (compare_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result        <= '0;
            overflow      <= 1'b0;
            compareResult <= CMP_EQ;
        end else begin
            result        <= result_next;
            overflow      <= overflow_next;
            compareResult <= compare_next;
        end
    end
endmodule

// File: tb/tb_ula.sv
// Directed-vector bench for ula with hand-computed expectations, checked one cycle after each input.
module tb_ula;
    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  opcode;
    logic [31:0] result;
    logic        overflow;
    logic [1:0]  compareResult;

    int checks_total  = 0;
    int checks_passed = 0;

    ula dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .opcode        (opcode),
        .result        (result),
        .overflow      (overflow),
        .compareResult (compareResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic [1:0]  cmp;
    } vec_t;

    // Apply inputs before an edge, sample at the following falling edge.
    task automatic run_vec(input vec_t v);
        opcode    = v.op;
        operand_a = v.a;
        operand_b = v.b;
        @(posedge clk);
        @(negedge clk);
        $display("%-8s op=%0d a=%08h b=%08h -> res=%08h ovf=%0b cmp=%02b",
                 v.tag, v.op, v.a, v.b, result, overflow, compareResult);
        check({v.tag, ".res"}, result, v.res);
        check({v.tag, ".ovf"}, {31'd0, overflow}, {31'd0, v.ovf});
        check({v.tag, ".cmp"}, {30'd0, compareResult}, {30'd0, v.cmp});
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        opcode = 4'd0; operand_a = 32'd5; operand_b = 32'd10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("reset    -> res=%08h ovf=%0b cmp=%02b", result, overflow, compareResult);
        check("rst.res", result, 32'd0);
        check("rst.ovf", {31'd0, overflow}, 32'd0);
        check("rst.cmp", {30'd0, compareResult}, 32'd0);
        rst_n = 1'b1;

        vecs.push_back('{"add",    4'd0,  32'd5,          32'd10,         32'd15,         1'b0, 2'b00});
        vecs.push_back('{"sub",    4'd1,  32'd20,         32'd8,          32'd12,         1'b0, 2'b00});
        vecs.push_back('{"mul",    4'd2,  32'd7,          32'd3,          32'd21,         1'b0, 2'b00});
        vecs.push_back('{"div",    4'd3,  32'd50,         32'd10,         32'd5,          1'b0, 2'b00});
        vecs.push_back('{"div7_2", 4'd3,  32'd7,          32'd2,          32'd3,          1'b0, 2'b00});
        vecs.push_back('{"and",    4'd4,  32'd1,          32'd1,          32'd1,          1'b0, 2'b00});
        vecs.push_back('{"and_m",  4'd4,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 2'b00});
        vecs.push_back('{"or",     4'd5,  32'd1,          32'd0,          32'd1,          1'b0, 2'b00});
        vecs.push_back('{"not",    4'd6,  32'd1,          32'd99,         32'hFFFF_FFFE,  1'b0, 2'b00});
        vecs.push_back('{"shl",    4'd7,  32'h3C,         32'd2,          32'h0000_00F0,  1'b0, 2'b00});
        vecs.push_back('{"shr",    4'd8,  32'h3C,         32'd1,          32'h0000_001E,  1'b0, 2'b00});
        vecs.push_back('{"shl40",  4'd7,  32'h3C,         32'd40,         32'd0,          1'b0, 2'b00});
        vecs.push_back('{"shl31",  4'd7,  32'd1,          32'd31,         32'h8000_0000,  1'b0, 2'b00});
        vecs.push_back('{"shr32",  4'd8,  32'hFFFF_FFFF,  32'd32,         32'd0,          1'b0, 2'b00});
        vecs.push_back('{"shrbig", 4'd8,  32'hFFFF_FFFF,  32'h0001_0001,  32'd0,          1'b0, 2'b00});
        vecs.push_back('{"cmp_lt", 4'd9,  32'd10,         32'd20,         32'd0,          1'b0, 2'b01});
        vecs.push_back('{"cmp_gt", 4'd9,  32'd20,         32'd10,         32'd0,          1'b0, 2'b10});
        vecs.push_back('{"cmp_eq", 4'd9,  32'd7,          32'd7,          32'd0,          1'b0, 2'b00});
        vecs.push_back('{"cmp_u",  4'd9,  32'h8000_0000,  32'd1,          32'd0,          1'b0, 2'b10});
        vecs.push_back('{"add_ov", 4'd0,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1, 2'b00});
        vecs.push_back('{"add_nn", 4'd0,  32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 2'b00});
        vecs.push_back('{"add_mx", 4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 2'b00});
        vecs.push_back('{"sub_ov", 4'd1,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 2'b00});
        vecs.push_back('{"sub_ov2",4'd1,  32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 2'b00});
        vecs.push_back('{"sub_neg",4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 2'b00});
        vecs.push_back('{"mul_ov", 4'd2,  32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 2'b00});
        vecs.push_back('{"mul_hi", 4'd2,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, 2'b00});
        vecs.push_back('{"div0",   4'd3,  32'd50,         32'd0,          32'hFFFF_FFFF,  1'b1, 2'b00});
        vecs.push_back('{"rsv15",  4'd15, 32'd5,          32'd10,         32'd0,          1'b0, 2'b00});
        vecs.push_back('{"rsv10",  4'd10, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 2'b00});
        // Consecutive-cycle pair: each result must land exactly one edge after its inputs.
        vecs.push_back('{"b2b_add",4'd0,  32'd100,        32'd23,         32'd123,        1'b0, 2'b00});
        vecs.push_back('{"b2b_sub",4'd1,  32'd100,        32'd23,         32'd77,         1'b0, 2'b00});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-stream must override the operation presented at that edge.
        rst_n = 1'b0;
        opcode = 4'd3; operand_a = 32'd1; operand_b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        $display("rst2     -> res=%08h ovf=%0b cmp=%02b", result, overflow, compareResult);
        check("rst2.res", result, 32'd0);
        check("rst2.ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        opcode = 4'd0; operand_a = 32'd5; operand_b = 32'd10;
        @(posedge clk);
        @(negedge clk);
        $display("release  -> res=%08h ovf=%0b cmp=%02b", result, overflow, compareResult);
        check("rel.res", result, 32'd15);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/ula.md
# ula

Registered 32-bit arithmetic/logic unit for the processor module. Performs one of ten operations (add, subtract, multiply, divide, AND, OR, NOT, shift left, shift right, compare) on two 32-bit operands selected by a 4-bit opcode. Results, an overflow flag and a 2-bit compare code are registered on the clock edge.

## Interface
- No parameters; data width fixed at 32 bits, opcode width fixed at 4 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- operand_a  input  32  first operand (A).
- operand_b  input  32  second operand (B); also the shift amount.
- opcode  input  4  operation select.
- result  output  32  registered operation result.
- overflow  output  1  registered overflow / error flag.
- compareResult  output  2  registered compare code.

## Operation
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A−B.
  - 0010 MUL: low 32 bits of unsigned A×B.
  - 0011 DIV: unsigned A/B, quotient truncated.
  - 0100 AND: A&B.
  - 0101 OR: A|B.
  - 0110 NOT: ~A; B ignored.
  - 0111 SHL: A logical-shift-left by B.
  - 1000 SHR: A logical-shift-right by B.
  - 1001 CMP: result=0; compare code produced.
  - 1010–1111 are reserved: result=0, overflow=0, compareResult=00.
- Overflow flag:
  - ADD/SUB: signed two's-complement overflow. ADD sets it when operands have the same sign and the sum sign differs. SUB sets it when operands differ in sign and the difference sign differs from A.
  - MUL: set when the upper 32 bits of the 64-bit unsigned product are non-zero.
  - DIV: set when B=0; in that case result=32'hFFFFFFFF.
  - All other opcodes: 0.
- Shifts: the full 32-bit B is the shift amount; if B≥32, result=0; no overflow.
- compareResult uses an unsigned comparison, only for CMP:
  - 00 when A==B.
  - 01 when A<B.
  - 10 when A>B.
  - 11 is never produced.
  - All non-CMP opcodes drive 00.
- Inputs are sampled every cycle; there is no handshake or valid signal.
- Every cycle computes a new result, so changing inputs are pipelined with no stall.

## Timing
- Latency: exactly 1 cycle. Inputs present before rising edge N appear on the outputs after edge N and hold until edge N+1.
- All arithmetic, including the 32-bit divide, completes combinationally within one cycle.
- Reset: when rst_n=0 at a rising edge, result=0, overflow=0, compareResult=00. Reset overrides any operation in flight.
- The first valid result is on the edge after rst_n is sampled high.
- Outputs change only on rising clk edges, never combinationally from the inputs.

## Structure
- Shared package ula_pkg:
  - opcode localparams: OP_ADD … OP_CMP, values 0–9.
  - compare encodings: CMP_EQ=2'b00, CMP_LT=2'b01, CMP_GT=2'b10.
  - DATA_W=32.
- One sub-module, ula_comb: purely combinational operation decode and datapath producing next result/overflow/compare.
- The ula top instantiates ula_comb and holds the three output registers with synchronous active-low reset.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with ADD 5,10 applied -> result=0, overflow=0, compareResult=00. Release reset -> result=15 after the next edge.
- Arithmetic: ADD 5+10 -> 15; SUB 20−8 -> 12; MUL 7×3 -> 21; DIV 50/10 -> 5. Overflow=0 for all four.
- Logic/shift:
  - AND 1&1 -> 1; OR 1|0 -> 1.
  - NOT 1 -> 32'hFFFFFFFE.
  - SHL 8'h3C by 2 -> 32'h000000F0; SHR 8'h3C by 1 -> 32'h0000001E; SHL by 40 -> 0.
- Compare: CMP 10,20 -> compareResult=01, result=0. CMP 20,10 -> 10. CMP 7,7 -> 00.
- Overflow and error cases:
  - ADD 32'h7FFFFFFF+1 -> 32'h80000000, overflow=1.
  - SUB 32'h80000000−1 -> overflow=1.
  - MUL 32'h00010000×32'h00010000 -> result 0, overflow=1.
  - DIV 50/0 -> 32'hFFFFFFFF, overflow=1.
- Back-to-back ops and reserved opcode:
  - ADD then SUB on consecutive cycles -> each result appears exactly one cycle after its inputs.
  - Opcode 4'b1111 -> result=0, overflow=0, compareResult=00.
